// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// State encoding, per-byte payload and index-width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    START = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_beat_t;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// wrapping explicitly at NumReq-1 so NumReq need not be a power of two.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned PtrW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [PtrW-1:0]   ptr,
  output logic [NumReq-1:0] pick,
  output logic              any
);

  localparam int unsigned SumW = PtrW + 1;

  logic [SumW-1:0] sum;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    pick  = '0;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      sum = {1'b0, ptr} + SumW'(i);
      if (sum >= SumW'(NumReq)) sum = sum - SumW'(NumReq);
      idx = sum[PtrW-1:0];
      if (!found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NumReq requesters: round-robin grant
// locked for a whole packet, per-byte strobe handshake, CTS gating, start timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NumReq       = 4,
  parameter int unsigned StartTimeout = 16,
  parameter bit          CtsEnable    = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NumReq-1:0]   i_req_valid,
  input  logic [8*NumReq-1:0] i_req_data,
  input  logic [NumReq-1:0]   i_req_last,
  output logic [NumReq-1:0]   o_req_ready,
  output logic [NumReq-1:0]   o_grant,
  output logic [7:0]          o_tx_byte,
  output logic                o_transmit,
  input  logic                i_is_transmitting,
  input  logic                i_uart_cts_n,
  input  logic                i_err_clr,
  output logic                o_busy,
  output logic                o_timeout_err
);

  localparam int unsigned     PtrW    = idx_width(NumReq);
  localparam int unsigned     CntW    = idx_width(StartTimeout);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(StartTimeout - 1);

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              last_q, last_d;
  logic              transmit_q, transmit_d;
  logic              err_q, err_d;
  logic              busy_q;

  logic [NumReq-1:0] pick;
  logic              any_valid;
  logic [PtrW-1:0]   g_idx, ptr_next;
  tx_beat_t          beat;
  logic              cts_ok, issue_ok, handshake;
  logic              release_byte, err_set;

  rr_arbiter #(
    .NumReq (NumReq),
    .PtrW   (PtrW)
  ) u_rr_arbiter (
    .valid (i_req_valid),
    .ptr   (ptr_q),
    .pick  (pick),
    .any   (any_valid)
  );

  // Payload and index of the current owner.
  always_comb begin
    beat  = '0;
    g_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (grant_q[k]) begin
        beat.data = i_req_data[8*k +: 8];
        beat.last = i_req_last[k];
        g_idx     = PtrW'(k);
      end
    end
  end

  assign ptr_next    = (g_idx == LastIdx) ? '0 : g_idx + PtrW'(1);
  assign cts_ok      = ~CtsEnable | ~i_uart_cts_n;
  assign issue_ok    = (state_q == READY) && !i_is_transmitting && cts_ok;
  assign o_req_ready = issue_ok ? grant_q : '0;
  assign handshake   = |(i_req_valid & o_req_ready);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tx_byte_d    = tx_byte_q;
    last_d       = last_q;
    transmit_d   = 1'b0;
    err_set      = 1'b0;
    release_byte = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          state_d = READY;
        end
      end
      READY: begin
        if (handshake) begin
          tx_byte_d  = beat.data;
          last_d     = beat.last;
          transmit_d = 1'b1;
          cnt_d      = '0;
          state_d    = START;
        end
      end
      START: begin
        // A core that never reports busy is treated as having sent the byte.
        if (i_is_transmitting) begin
          state_d = DONE;
        end else if (cnt_q == CntMax) begin
          err_set      = 1'b1;
          release_byte = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (!i_is_transmitting) release_byte = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (release_byte) begin
      if (last_q) begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end else begin
        state_d = READY;
      end
    end
    err_d = err_set | (err_q & ~i_err_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= '0;
      last_q     <= 1'b0;
      transmit_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      last_q     <= last_d;
      transmit_q <= transmit_d;
      err_q      <= err_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign o_grant       = grant_q;
  assign o_tx_byte     = tx_byte_q;
  assign o_transmit    = transmit_q;
  assign o_busy        = busy_q;
  assign o_timeout_err = err_q;

endmodule
